// File: rtl/dp_ram_pkg.sv
// Shared definitions for the byte-enable dual-port RAM: read-during-write
// encodings, clear-sweep state type and the byte-lane merge helper.
package dp_ram_pkg;

  localparam int unsigned RDW_READ_FIRST  = 0;
  localparam int unsigned RDW_WRITE_FIRST = 1;

  // merge_bytes works on a fixed maximum width; callers size in and out.
  localparam int unsigned MERGE_MAX_W  = 512;
  localparam int unsigned MERGE_MAX_BE = MERGE_MAX_W / 8;

  typedef enum logic {
    INIT,
    RUN
  } clr_state_t;

  function automatic logic [MERGE_MAX_W-1:0] merge_bytes(
    input logic [MERGE_MAX_W-1:0]  old_word,
    input logic [MERGE_MAX_W-1:0]  new_word,
    input logic [MERGE_MAX_BE-1:0] be
  );
    logic [MERGE_MAX_W-1:0] res;
    res = old_word;
    for (int unsigned i = 0; i < MERGE_MAX_BE; i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dp_ram_rd_pipe.sv
// Per-port read output stage: one or two register stages of data/valid,
// flushed by the synchronous reset.
module dp_ram_rd_pipe #(
  parameter int unsigned W            = 32,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         req,
  input  logic [W-1:0] din,
  output logic [W-1:0] rdata,
  output logic         rvalid
);

  if (READ_LATENCY == 2) begin : g_lat2
    logic         s1_valid;
    logic [W-1:0] s1_data;

    always_ff @(posedge CLK) begin
      if (!RST_N) begin
        s1_valid <= 1'b0;
        s1_data  <= '0;
        rvalid   <= 1'b0;
        rdata    <= '0;
      end else begin
        s1_valid <= req;
        if (req) s1_data <= din;
        rvalid <= s1_valid;
        if (s1_valid) rdata <= s1_data;
      end
    end
  end else begin : g_lat1
    always_ff @(posedge CLK) begin
      if (!RST_N) begin
        rvalid <= 1'b0;
        rdata  <= '0;
      end else begin
        rvalid <= req;
        if (req) rdata <= din;
      end
    end
  end

endmodule

// File: rtl/dual_port_ram_be.sv
// True dual-port RAM with byte enables, 1/2-cycle read latency, write
// collision arbitration (port A wins per lane) and a post-reset clear sweep.
module dual_port_ram_be
  import dp_ram_pkg::*;
#(
  parameter int unsigned N              = 4,
  parameter int unsigned D              = 16,
  parameter int unsigned W              = 32,
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned RDW_MODE       = RDW_READ_FIRST,
  parameter int unsigned CLEAR_ON_RESET = 1,
  localparam int unsigned BE_W          = W / 8
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            CS,
  input  logic            EN_A,
  input  logic            WE_A,
  input  logic [BE_W-1:0] BE_A,
  input  logic [N-1:0]    ADDR_A,
  input  logic [W-1:0]    WDATA_A,
  output logic [W-1:0]    RDATA_A,
  output logic            RVALID_A,
  input  logic            EN_B,
  input  logic            WE_B,
  input  logic [BE_W-1:0] BE_B,
  input  logic [N-1:0]    ADDR_B,
  input  logic [W-1:0]    WDATA_B,
  output logic [W-1:0]    RDATA_B,
  output logic            RVALID_B,
  output logic            COLLISION,
  output logic            INIT_BUSY
);

  localparam int unsigned AW = (D > 1) ? $clog2(D) : 1;

  logic [W-1:0]  mem [D];
  clr_state_t    state;
  logic [AW-1:0] clr_cnt;
  logic [AW-1:0] idx_a, idx_b;
  logic          acc_a, acc_b, inr_a, inr_b;
  logic          wr_a, wr_b, rd_a, rd_b, col_hit;
  logic [W-1:0]  raw_a, raw_b;

  function automatic logic [W-1:0] merge(
    input logic [W-1:0]    old_word,
    input logic [W-1:0]    new_word,
    input logic [BE_W-1:0] be
  );
    return W'(merge_bytes(MERGE_MAX_W'(old_word), MERGE_MAX_W'(new_word),
                          MERGE_MAX_BE'(be)));
  endfunction

  function automatic logic [W-1:0] rd_mux(
    input logic            in_range,
    input logic            own_wr,
    input logic [W-1:0]    word,
    input logic [W-1:0]    wdata,
    input logic [BE_W-1:0] be
  );
    if (!in_range) return '0;
    if (RDW_MODE == RDW_WRITE_FIRST && own_wr) return merge(word, wdata, be);
    return word;
  endfunction

  assign INIT_BUSY = (state == INIT);

  assign acc_a   = RST_N && !CS && EN_A && !INIT_BUSY;
  assign acc_b   = RST_N && !CS && EN_B && !INIT_BUSY;
  assign inr_a   = (32'(ADDR_A) < D);
  assign inr_b   = (32'(ADDR_B) < D);
  assign idx_a   = AW'(ADDR_A);
  assign idx_b   = AW'(ADDR_B);
  assign wr_a    = acc_a && WE_A && inr_a;
  assign wr_b    = acc_b && WE_B && inr_b;
  assign rd_a    = acc_a && !WE_A;
  assign rd_b    = acc_b && !WE_B;
  assign col_hit = wr_a && wr_b && (ADDR_A == ADDR_B);

  assign raw_a = rd_mux(inr_a, wr_a, mem[idx_a], WDATA_A, BE_A);
  assign raw_b = rd_mux(inr_b, wr_b, mem[idx_b], WDATA_B, BE_B);

  // Port B lanes are scheduled first so port A's later assignment wins any
  // lane both ports enable on a collision.
  always_ff @(posedge CLK) begin
    if (RST_N && state == INIT) begin
      mem[clr_cnt] <= '0;
    end else begin
      for (int unsigned i = 0; i < BE_W; i++) begin
        if (wr_b && BE_B[i]) mem[idx_b][8*i +: 8] <= WDATA_B[8*i +: 8];
        if (wr_a && BE_A[i]) mem[idx_a][8*i +: 8] <= WDATA_A[8*i +: 8];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= (CLEAR_ON_RESET != 0) ? INIT : RUN;
      clr_cnt   <= '0;
      COLLISION <= 1'b0;
    end else begin
      COLLISION <= col_hit;
      if (state == INIT) begin
        clr_cnt <= clr_cnt + AW'(1);
        if (clr_cnt == AW'(D - 1)) state <= RUN;
      end
    end
  end

  dp_ram_rd_pipe #(
    .W            (W),
    .READ_LATENCY (READ_LATENCY)
  ) u_rd_pipe_a (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .req    (rd_a),
    .din    (raw_a),
    .rdata  (RDATA_A),
    .rvalid (RVALID_A)
  );

  dp_ram_rd_pipe #(
    .W            (W),
    .READ_LATENCY (READ_LATENCY)
  ) u_rd_pipe_b (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .req    (rd_b),
    .din    (raw_b),
    .rdata  (RDATA_B),
    .rvalid (RVALID_B)
  );

endmodule

// File: tb/tb_dual_port_ram_be.sv
// Scoreboard bench: two RAM instances (read latency 2 and 1) share one
// stimulus stream; a monitor checks every read response and collision pulse.
module tb_dual_port_ram_be;

  logic        CLK = 1'b0;
  logic        RST_N, CS;
  logic        EN_A, WE_A, EN_B, WE_B;
  logic [3:0]  BE_A, BE_B;
  logic [4:0]  ADDR_A, ADDR_B;
  logic [31:0] WDATA_A, WDATA_B;

  logic [31:0] rd2_a, rd2_b, rd1_a, rd1_b;
  logic        rv2_a, rv2_b, rv1_a, rv1_b;
  logic        col2, col1, busy2, busy1;

  always #5 CLK = ~CLK;

  dual_port_ram_be #(
    .N(5), .D(16), .W(32), .READ_LATENCY(2), .RDW_MODE(0), .CLEAR_ON_RESET(1)
  ) u_dut2 (
    .CLK(CLK), .RST_N(RST_N), .CS(CS),
    .EN_A(EN_A), .WE_A(WE_A), .BE_A(BE_A), .ADDR_A(ADDR_A), .WDATA_A(WDATA_A),
    .RDATA_A(rd2_a), .RVALID_A(rv2_a),
    .EN_B(EN_B), .WE_B(WE_B), .BE_B(BE_B), .ADDR_B(ADDR_B), .WDATA_B(WDATA_B),
    .RDATA_B(rd2_b), .RVALID_B(rv2_b),
    .COLLISION(col2), .INIT_BUSY(busy2)
  );

  dual_port_ram_be #(
    .N(5), .D(16), .W(32), .READ_LATENCY(1), .RDW_MODE(0), .CLEAR_ON_RESET(1)
  ) u_dut1 (
    .CLK(CLK), .RST_N(RST_N), .CS(CS),
    .EN_A(EN_A), .WE_A(WE_A), .BE_A(BE_A), .ADDR_A(ADDR_A), .WDATA_A(WDATA_A),
    .RDATA_A(rd1_a), .RVALID_A(rv1_a),
    .EN_B(EN_B), .WE_B(WE_B), .BE_B(BE_B), .ADDR_B(ADDR_B), .WDATA_B(WDATA_B),
    .RDATA_B(rd1_b), .RVALID_B(rv1_b),
    .COLLISION(col1), .INIT_BUSY(busy1)
  );

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } exp_t;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t rq [4][$];
  int   cq [2][$];
  exp_t e;
  int   ce;

  // index = dut*2 + port; dut 0 = latency 2, dut 1 = latency 1
  logic        rv  [4];
  logic [31:0] rdv [4];
  logic        colv[2];
  assign rv[0] = rv2_a;  assign rdv[0] = rd2_a;
  assign rv[1] = rv2_b;  assign rdv[1] = rd2_b;
  assign rv[2] = rv1_a;  assign rdv[2] = rd1_a;
  assign rv[3] = rv1_b;  assign rdv[3] = rd1_b;
  assign colv[0] = col2;
  assign colv[1] = col1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exv);
    total++;
    if (act !== exv) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exv, cyc);
    end
  endtask

  always @(posedge CLK) cyc++;

  always @(posedge CLK) begin
    #1;
    for (int i = 0; i < 4; i++) begin
      if (rv[i]) begin
        if (rq[i].size() == 0) begin
          total++; bad++;
          $display("FAIL spurious_rvalid[%0d]: got 1 expected 0 (cycle %0d)", i, cyc);
        end else begin
          e = rq[i].pop_front();
          check($sformatf("rdata[%0d]", i), rdv[i], e.data);
          check($sformatf("rcycle[%0d]", i), cyc, e.cyc);
        end
      end else if (rq[i].size() > 0 && rq[i][0].cyc <= cyc) begin
        e = rq[i].pop_front();
        total++; bad++;
        $display("FAIL missing_rvalid[%0d]: got 0 expected 1 (cycle %0d)", i, e.cyc);
      end
    end
    for (int d = 0; d < 2; d++) begin
      if (colv[d]) begin
        if (cq[d].size() == 0) begin
          total++; bad++;
          $display("FAIL spurious_collision[%0d]: got 1 expected 0 (cycle %0d)", d, cyc);
        end else begin
          ce = cq[d].pop_front();
          check($sformatf("col_cycle[%0d]", d), cyc, ce);
        end
      end else if (cq[d].size() > 0 && cq[d][0] <= cyc) begin
        ce = cq[d].pop_front();
        total++; bad++;
        $display("FAIL missing_collision[%0d]: got 0 expected 1 (cycle %0d)", d, ce);
      end
    end
  end

  task automatic idle_ports();
    EN_A = 1'b0; WE_A = 1'b0; BE_A = '0;
    EN_B = 1'b0; WE_B = 1'b0; BE_B = '0;
  endtask

  task automatic tick();
    @(negedge CLK);
    idle_ports();
  endtask

  task automatic wr(input int port, input logic [4:0] a, input logic [31:0] d,
                    input logic [3:0] be);
    if (port == 0) begin
      EN_A = 1'b1; WE_A = 1'b1; ADDR_A = a; WDATA_A = d; BE_A = be;
    end else begin
      EN_B = 1'b1; WE_B = 1'b1; ADDR_B = a; WDATA_B = d; BE_B = be;
    end
  endtask

  // mask bit d selects which instance is expected to answer
  task automatic rd(input int port, input logic [4:0] a, input logic [31:0] x,
                    input logic [1:0] mask);
    exp_t t;
    if (port == 0) begin
      EN_A = 1'b1; WE_A = 1'b0; ADDR_A = a;
    end else begin
      EN_B = 1'b1; WE_B = 1'b0; ADDR_B = a;
    end
    for (int d = 0; d < 2; d++) begin
      if (mask[d]) begin
        t.cyc  = cyc + ((d == 0) ? 2 : 1);
        t.data = x;
        rq[d*2 + port].push_back(t);
      end
    end
  endtask

  task automatic exp_col();
    for (int d = 0; d < 2; d++) cq[d].push_back(cyc + 1);
  endtask

  task automatic wait_init(input string tag);
    int n2, n1, k;
    n2 = 0; n1 = 0; k = 0;
    while ((busy2 || busy1) && k < 40) begin
      if (busy2) n2++;
      if (busy1) n1++;
      k++;
      @(negedge CLK);
    end
    check({tag, "_len_lat2"}, n2, 16);
    check({tag, "_len_lat1"}, n1, 16);
  endtask

  initial begin
    RST_N = 1'b0; CS = 1'b0;
    idle_ports();
    ADDR_A = '0; ADDR_B = '0; WDATA_A = '0; WDATA_B = '0;
    repeat (3) @(negedge CLK);

    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_rdata[%0d]", i), rdv[i], 32'h0);
      check($sformatf("rst_rvalid[%0d]", i), rv[i], 1'b0);
    end
    check("rst_col2", col2, 1'b0);
    check("rst_col1", col1, 1'b0);
    check("rst_busy2", busy2, 1'b1);
    check("rst_busy1", busy1, 1'b1);

    // release reset with a read held on B; it must be ignored during INIT
    RST_N = 1'b1;
    EN_B = 1'b1; WE_B = 1'b0; ADDR_B = 5'd2;
    wait_init("init");
    idle_ports();

    for (int a = 0; a < 16; a++) begin
      rd(0, 5'(a), 32'h0, 2'b11);
      tick();
    end
    repeat (3) tick();

    wr(0, 5'd3, 32'hAABBCCDD, 4'b1111); tick();
    wr(0, 5'd3, 32'h11223344, 4'b0101); tick();
    rd(1, 5'd3, 32'hAA22CC44, 2'b11);   tick();

    wr(0, 5'd0, 32'h10, 4'b1111); tick();
    wr(0, 5'd1, 32'h21, 4'b1111); tick();
    wr(0, 5'd2, 32'h32, 4'b1111); tick();
    rd(1, 5'd0, 32'h10, 2'b11); tick();
    rd(1, 5'd1, 32'h21, 2'b11); tick();
    rd(1, 5'd2, 32'h32, 2'b11); tick();

    wr(0, 5'd5, 32'h000000FF, 4'b0001);
    wr(1, 5'd5, 32'h12345678, 4'b1111);
    exp_col();
    tick();
    tick();
    rd(0, 5'd5, 32'h123456FF, 2'b11); tick();

    wr(0, 5'd7, 32'h5, 4'b1111); tick();
    wr(0, 5'd7, 32'h9, 4'b1111);
    rd(1, 5'd7, 32'h5, 2'b11);   tick();
    rd(1, 5'd7, 32'h9, 2'b11);   tick();

    // address 21 would alias onto 5 if the range check were missing
    wr(0, 5'd21, 32'hDEADBEEF, 4'b1111); tick();
    rd(1, 5'd21, 32'h0, 2'b11);          tick();
    rd(0, 5'd5, 32'h123456FF, 2'b11);    tick();
    wr(0, 5'd3, 32'h0, 4'b0000);         tick();
    rd(0, 5'd3, 32'hAA22CC44, 2'b11);    tick();

    wr(0, 5'd8, 32'hCAFE0008, 4'b1111);
    wr(1, 5'd9, 32'hBEEF0009, 4'b1111); tick();
    rd(0, 5'd9, 32'hBEEF0009, 2'b11);
    rd(1, 5'd8, 32'hCAFE0008, 2'b11);   tick();

    rd(1, 5'd0, 32'h10, 2'b11); tick();
    CS = 1'b1; EN_B = 1'b1; WE_B = 1'b0; ADDR_B = 5'd1;
    tick();
    CS = 1'b0;
    repeat (3) tick();

    // latency-1 instance answers before reset lands; latency-2 is flushed
    rd(0, 5'd3, 32'hAA22CC44, 2'b10); tick();
    RST_N = 1'b0;
    @(negedge CLK);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("midrst_rdata[%0d]", i), rdv[i], 32'h0);
      check($sformatf("midrst_rvalid[%0d]", i), rv[i], 1'b0);
    end
    check("midrst_busy2", busy2, 1'b1);
    check("midrst_busy1", busy1, 1'b1);
    RST_N = 1'b1;
    wait_init("reinit");
    rd(0, 5'd3, 32'h0, 2'b11);
    rd(1, 5'd0, 32'h0, 2'b11); tick();

    repeat (5) tick();
    for (int i = 0; i < 4; i++) check($sformatf("drain_rq[%0d]", i), rq[i].size(), 0);
    for (int d = 0; d < 2; d++) check($sformatf("drain_cq[%0d]", d), cq[d].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
